// File: rtl/jtpinpon_obj_pkg.sv
// Object RAM layout, attribute bit positions and scanner state encoding
// shared by the Ping Pong object pipeline.
package jtpinpon_obj_pkg;

    localparam logic [1:0] OBJ_X    = 2'd0;
    localparam logic [1:0] OBJ_Y    = 2'd1;
    localparam logic [1:0] OBJ_CODE = 2'd2;
    localparam logic [1:0] OBJ_ATTR = 2'd3;

    localparam int ATTR_VFLIP   = 7;
    localparam int ATTR_HFLIP   = 6;
    localparam int ATTR_PAL_MSB = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_ISSUE,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/jtpinpon_objscan.sv
// Per-line object scanner: 6 cen2 per object (4 address, 1 RAM latency, 1 compare), NOBJ-1 down to 0.
// A hit stalls in ISSUE until busy is low; the next object is prefetched while the draw stage works.
module jtpinpon_objscan
    import jtpinpon_obj_pkg::*;
#(
    parameter int         NOBJ    = 32,
    parameter logic [7:0] VOFFSET = 8'd0
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen2,
    input  logic       hinit_x,
    input  logic [7:0] vrender,
    output logic [6:0] ram_addr,
    input  logic [7:0] ram_dout,
    output logic       draw,
    input  logic       busy,
    output logic [7:0] xpos,
    output logic [3:0] ysub,
    output logic [4:0] pal,
    output logic       hflip,
    output logic       vflip,
    output logic [7:0] code,
    output logic       done
);

    localparam logic [4:0] LAST_OBJ = 5'(NOBJ - 1);

    scan_state_t r_state;
    scan_state_t w_state_nx;

    logic [2:0] r_cnt;
    logic [4:0] r_idx;
    logic [7:0] r_vline;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_code;
    logic [7:0] r_attr;
    logic [6:0] r_addr;
    logic       r_draw;
    logic       r_done;
    logic [7:0] r_xpos;
    logic [3:0] r_ysub;
    logic [4:0] r_pal;
    logic       r_hflip;
    logic       r_vflip;
    logic [7:0] r_code_out;

    logic [7:0] w_ydiff;
    logic       w_hit;
    logic       w_grant;
    logic       w_adv;
    logic [4:0] w_idx_dec;
    logic [1:0] w_byte;
    logic       w_unused;

    // Mod-256 difference makes Y wrap-around (e.g. Y=250 on line 4) a normal hit.
    assign w_ydiff   = r_vline - r_y;
    assign w_hit     = (w_ydiff[7:4] == 4'd0);
    assign w_idx_dec = r_idx - 5'd1;
    assign w_byte    = r_cnt[1:0] - 2'd1;
    assign w_unused  = r_attr[5];

    // Index advance is folded into CHECK (miss) and ISSUE (grant) so neither costs an extra cen2.
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_adv      = 1'b0;
        if (hinit_x) begin
            w_state_nx = ST_READ;
        end else begin
            case (r_state)
                ST_READ: begin
                    if (r_cnt == 3'd4)
                        w_state_nx = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_hit) begin
                        w_state_nx = ST_ISSUE;
                    end else begin
                        w_adv      = 1'b1;
                        w_state_nx = (r_idx == 5'd0) ? ST_DONE : ST_READ;
                    end
                end
                ST_ISSUE: begin
                    if (!busy) begin
                        w_grant    = 1'b1;
                        w_adv      = 1'b1;
                        w_state_nx = (r_idx == 5'd0) ? ST_DONE : ST_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else if (cen2)
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 3'd0;
            r_idx      <= 5'd0;
            r_vline    <= 8'd0;
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_code     <= 8'd0;
            r_attr     <= 8'd0;
            r_addr     <= 7'd0;
            r_draw     <= 1'b0;
            r_done     <= 1'b0;
            r_xpos     <= 8'd0;
            r_ysub     <= 4'd0;
            r_pal      <= 5'd0;
            r_hflip    <= 1'b0;
            r_vflip    <= 1'b0;
            r_code_out <= 8'd0;
        end else if (cen2) begin
            r_draw <= w_grant;
            if (hinit_x) begin
                r_done  <= 1'b0;
                r_idx   <= LAST_OBJ;
                r_cnt   <= 3'd0;
                r_vline <= vrender + VOFFSET;
            end else begin
                if (r_state == ST_READ) begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd4)
                        r_addr <= {r_idx, r_cnt[1:0]};
                    if (r_cnt != 3'd0) begin
                        case (w_byte)
                            OBJ_X:    r_x    <= ram_dout;
                            OBJ_Y:    r_y    <= ram_dout;
                            OBJ_CODE: r_code <= ram_dout;
                            default:  r_attr <= ram_dout;
                        endcase
                    end
                end
                // Output fields live apart from the scan capture so prefetch cannot disturb a draw.
                if (w_grant) begin
                    r_xpos     <= r_x;
                    r_ysub     <= w_ydiff[3:0];
                    r_pal      <= r_attr[ATTR_PAL_MSB:0];
                    r_hflip    <= r_attr[ATTR_HFLIP];
                    r_vflip    <= r_attr[ATTR_VFLIP];
                    r_code_out <= r_code;
                end
                if (w_adv) begin
                    if (r_idx == 5'd0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_idx <= w_idx_dec;
                        r_cnt <= w_grant ? 3'd1 : 3'd0;
                        if (w_grant)
                            r_addr <= {w_idx_dec, OBJ_X};
                    end
                end
            end
        end
    end

    assign ram_addr = r_addr;
    assign draw     = r_draw;
    assign done     = r_done;
    assign xpos     = r_xpos;
    assign ysub     = r_ysub;
    assign pal      = r_pal;
    assign hflip    = r_hflip;
    assign vflip    = r_vflip;
    assign code     = r_code_out;

endmodule
